// File: rtl/fila_pedidos_param.sv
// -----------------------------------------------------------------------------
// fila_pedidos_param
// Parametrised request queue for the SmartCargo controller. It holds up to
// DEPTH transport requests {eh_origem, tipo, origem, destino}. Entry 0 is the
// head, and the trajectory FSM consumes it.
//
// Supported operations:
//   - tail push and head pop, including push and pop on the same edge
//   - mid-queue insert (fit) and in-place overwrite (we)
//   - synchronous flush (clear)
// An illegal command leaves storage and count unchanged. It raises err for
// exactly one cycle.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   clear                 synchronous flush of every entry
//   push / pop / fit / we queue commands (priority clear>fit>push&pop>push>pop>we)
//   ins_addr, addr        fit insert position, we target index
//   in_*                  request fields written by push / fit / we
//   rd_addr, rd_prev_addr secondary read indices
//   eh_origem..destino_objeto  head entry fields
//   sec_destino, sec_prev_destino  destino at rd_addr / rd_prev_addr (0 if invalid)
//   count, empty, full    occupancy
//   err                   one-cycle pulse for a rejected command
// -----------------------------------------------------------------------------
module fila_pedidos_param #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int FLOOR_W = 2,
  parameter int TYPE_W  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic               fit,
  input  logic [ADDR_W-1:0]  ins_addr,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               in_eh_origem,
  input  logic [TYPE_W-1:0]  in_tipo_objeto,
  input  logic [FLOOR_W-1:0] in_origem_objeto,
  input  logic [FLOOR_W-1:0] in_destino_objeto,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [ADDR_W-1:0]  rd_prev_addr,
  output logic               eh_origem,
  output logic [TYPE_W-1:0]  tipo_objeto,
  output logic [FLOOR_W-1:0] origem_objeto,
  output logic [FLOOR_W-1:0] destino_objeto,
  output logic [FLOOR_W-1:0] sec_destino,
  output logic [FLOOR_W-1:0] sec_prev_destino,
  output logic [ADDR_W:0]    count,
  output logic               empty,
  output logic               full,
  output logic               err
);

  localparam int ENTRY_W = 1 + TYPE_W + 2 * FLOOR_W;
  localparam int CNT_W   = ADDR_W + 1;

  // Entry layout: {eh_origem, tipo, origem, destino}; destino occupies the LSBs.
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;

  logic [ENTRY_W-1:0] in_entry_s;
  logic [ENTRY_W-1:0] up_s   [DEPTH];  // mem_q moved one slot toward the tail
  logic [ENTRY_W-1:0] down_s [DEPTH];  // mem_q moved one slot toward the head
  logic               fit_ok_s, push_ok_s, pop_ok_s, we_ok_s;

  assign in_entry_s = {in_eh_origem, in_tipo_objeto, in_origem_objeto, in_destino_objeto};

  // The index inputs are zero-extended to count width. An index >= DEPTH then
  // fails these checks automatically, because count never exceeds DEPTH.
  assign push_ok_s = (count_q < CNT_W'(DEPTH));
  assign pop_ok_s  = (count_q != {CNT_W{1'b0}});
  assign fit_ok_s  = push_ok_s && ({1'b0, ins_addr} <= count_q);
  assign we_ok_s   = ({1'b0, addr} < count_q);

  // Shifted copies of the storage, shared by the fit, pop and push&pop paths.
  always_comb begin
    up_s[0] = {ENTRY_W{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      up_s[i] = mem_q[i-1];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      down_s[i] = mem_q[i+1];
    end
    down_s[DEPTH-1] = {ENTRY_W{1'b0}};
  end

  // Next-state selection. Only the highest-priority asserted command takes effect.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = {ENTRY_W{1'b0}};
      end
      count_d = {CNT_W{1'b0}};
    end else if (fit) begin
      if (fit_ok_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(ins_addr)) begin
            mem_d[i] = in_entry_s;
          end else if ((i > int'(ins_addr)) && (i <= int'(count_q))) begin
            mem_d[i] = up_s[i];
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
        count_d = count_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (push && pop) begin
      if (pop_ok_s) begin
        // Shift toward the head, then refill the old tail slot. Count is unchanged.
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(count_q) - 1) begin
            mem_d[i] = in_entry_s;
          end else begin
            mem_d[i] = down_s[i];
          end
        end
      end else begin
        // An empty queue has nothing to pop, so the command acts as a plain push.
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(count_q)) begin
            mem_d[i] = in_entry_s;
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
        count_d = count_q + CNT_W'(1);
      end
    end else if (push) begin
      if (push_ok_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(count_q)) begin
            mem_d[i] = in_entry_s;
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
        count_d = count_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (pop) begin
      if (pop_ok_s) begin
        // Unused slots are already zero, so the vacated tail reads as zero after the shift.
        mem_d   = down_s;
        count_d = count_q - CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (we) begin
      if (we_ok_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(addr)) begin
            mem_d[i] = in_entry_s;
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Storage, occupancy and error-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
      count_q <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Secondary read ports. An index outside the valid range reads as zero.
  always_comb begin
    sec_destino      = {FLOOR_W{1'b0}};
    sec_prev_destino = {FLOOR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if ((i == int'(rd_addr)) && (i < int'(count_q))) begin
        sec_destino = mem_q[i][FLOOR_W-1:0];
      end else begin
        sec_destino = sec_destino;
      end
      if ((i == int'(rd_prev_addr)) && (i < int'(count_q))) begin
        sec_prev_destino = mem_q[i][FLOOR_W-1:0];
      end else begin
        sec_prev_destino = sec_prev_destino;
      end
    end
  end

  assign {eh_origem, tipo_objeto, origem_objeto, destino_objeto} = mem_q[0];
  assign count = count_q;
  assign empty = (count_q == {CNT_W{1'b0}});
  assign full  = (count_q == CNT_W'(DEPTH));
  assign err   = err_q;

endmodule
